control_unit: RTL and testbench

- Multi-cycle instruction sequencer for the simple 16-bit processor datapath.
- Drives the select side of the shared bus multiplexer (Rout, Gout, DINout) and the register, accumulator and ALU load/operation controls.
- Fetches a 9-bit instruction word from DIN, then steps through up to three execute cycles.
- Pulses Done on the final cycle of each instruction.

---
 rtl/control_unit_pkg.sv | 29 ++
 rtl/control_unit_if.sv | 31 +++
 rtl/control_unit_dec3to8.sv | 16 +
 rtl/control_unit.sv | 123 ++++++++++++
 tb/tb_control_unit.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/control_unit_pkg.sv
// Shared constants for the instruction sequencer: opcodes, FSM states, IR field positions.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ctrl_pkg;

    // Opcode field values (IR[8:6])
    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVNZ = 3'b100;

    // IR field positions
    localparam int OP_HI = 8;
    localparam int OP_LO = 6;
    localparam int RX_HI = 5;
    localparam int RX_LO = 3;
    localparam int RY_HI = 2;
    localparam int RY_LO = 0;

    // Sequencer time steps
    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

endpackage

// File: rtl/control_unit_if.sv
// Control/bus-select bundle between the sequencer and the processor datapath.
// Latency: n/a (wiring only).
// Backpressure: none; Run is a level request sampled by the sequencer in T0.
interface control_unit_if #(
    parameter int DIN_W = 16
);
    logic             Run;
    logic [DIN_W-1:0] DIN;
    logic             Gnz;
    logic             IRin;
    logic [0:7]       Rout;
    logic             Gout;
    logic             DINout;
    logic [0:7]       Rin;
    logic             Ain;
    logic             Gin;
    logic             AddSub;
    logic             Done;

    // Sequencer side
    modport master (
        input  Run, DIN, Gnz,
        output IRin, Rout, Gout, DINout, Rin, Ain, Gin, AddSub, Done
    );

    // Datapath side
    modport slave (
        output Run, DIN, Gnz,
        input  IRin, Rout, Gout, DINout, Rin, Ain, Gin, AddSub, Done
    );
endinterface

// File: rtl/control_unit_dec3to8.sv
// 3-bit register code to [0:7] one-hot select; code 0 -> 8'b10000000 (R0 in the leftmost bit).
// Latency: combinational.
// Backpressure: none; en=0 forces all-zero.
module dec3to8 (
    input  logic       en,
    input  logic [2:0] code,
    output logic [0:7] onehot
);
    // Bit 0 of a [0:7] vector is the MSB, so shifting right by code sets onehot[code]
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot = 8'b1000_0000 >> code;
        end
    end
endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer: fetch (T0) then up to three execute steps, Done on the last step.
// Latency: mv/mvi/illegal 2 cycles, add/sub 4 cycles; outputs combinational from state/IR/Run/Gnz.
// Backpressure: Run sampled only in T0; ignored in T1..T3. Optional mvnz opcode via CTRL_MVNZ_EN.
module control_unit
    import ctrl_pkg::*;
#(
    parameter int IR_W  = 9,
    parameter int DIN_W = 16
) (
    input  logic          Clock,
    input  logic          Resetn,
    control_unit_if.master bus
);

    state_t          state, state_nxt;
    logic [IR_W-1:0] ir;
    logic [2:0]      op;
    logic [0:7]      rx_oh, ry_oh;

    logic ir_ld, rout_x, rout_y, rin_x;
    logic gout, dinout, ain, gin, addsub, done;

    assign op = ir[OP_HI:OP_LO];

    // Datapath-side DIN upper bits are never decoded here; Gnz only matters with mvnz
    logic unused_inputs;
    assign unused_inputs = ^{bus.DIN[DIN_W-1:IR_W], bus.Gnz};

    // Decoder enables double as reset gating for the one-hot selects
    dec3to8 u_dec_rx (.en(Resetn), .code(ir[RX_HI:RX_LO]), .onehot(rx_oh));
    dec3to8 u_dec_ry (.en(Resetn), .code(ir[RY_HI:RY_LO]), .onehot(ry_oh));

    // State and instruction register
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= T0;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (ir_ld) begin
                ir <= bus.DIN[IR_W-1:0];
            end
        end
    end

    // Next state and per-step control decode
    always_comb begin
        state_nxt = T0;
        ir_ld     = 1'b0;
        rout_x    = 1'b0;
        rout_y    = 1'b0;
        rin_x     = 1'b0;
        gout      = 1'b0;
        dinout    = 1'b0;
        ain       = 1'b0;
        gin       = 1'b0;
        addsub    = 1'b0;
        done      = 1'b0;
        case (state)
            T0: begin
                if (bus.Run) begin
                    ir_ld     = 1'b1;
                    state_nxt = T1;
                end
            end
            T1: begin
                case (op)
                    OP_MV: begin
                        rout_y = 1'b1;
                        rin_x  = 1'b1;
                        done   = 1'b1;
                    end
                    OP_MVI: begin
                        dinout = 1'b1;
                        rin_x  = 1'b1;
                        done   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        rout_x    = 1'b1;
                        ain       = 1'b1;
                        state_nxt = T2;
                    end
`ifdef CTRL_MVNZ_EN
                    OP_MVNZ: begin
                        // Conditional move: nothing driven or loaded when G is zero
                        rout_y = bus.Gnz;
                        rin_x  = bus.Gnz;
                        done   = 1'b1;
                    end
`endif
                    default: begin
                        done = 1'b1;
                    end
                endcase
            end
            T2: begin
                // Only add/sub reach T2
                rout_y    = 1'b1;
                gin       = 1'b1;
                addsub    = (op == OP_SUB);
                state_nxt = T3;
            end
            T3: begin
                gout  = 1'b1;
                rin_x = 1'b1;
                done  = 1'b1;
            end
            default: state_nxt = T0;
        endcase
    end

    // Output drive; everything is forced low while reset is held
    assign bus.IRin   = Resetn & ir_ld;
    assign bus.Rout   = rout_x ? rx_oh : (rout_y ? ry_oh : 8'b0);
    assign bus.Rin    = rin_x ? rx_oh : 8'b0;
    assign bus.Gout   = Resetn & gout;
    assign bus.DINout = Resetn & dinout;
    assign bus.Ain    = Resetn & ain;
    assign bus.Gin    = Resetn & gin;
    assign bus.AddSub = Resetn & addsub;
    assign bus.Done   = Resetn & done;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

    logic Clock;
    logic Resetn;
    int   n_checks;
    int   n_errors;

    control_unit_if #(.DIN_W(16)) cif ();

    control_unit #(.IR_W(9), .DIN_W(16)) dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .bus   (cif)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Observed outputs packed: {IRin, Rout, Gout, DINout, Rin, Ain, Gin, AddSub, Done}
    logic [22:0] obs;
    assign obs = {cif.IRin, cif.Rout, cif.Gout, cif.DINout, cif.Rin,
                  cif.Ain, cif.Gin, cif.AddSub, cif.Done};

    function automatic logic [22:0] ev(input logic irin, input logic [0:7] rout,
                                       input logic gout, input logic dinout,
                                       input logic [0:7] rin, input logic ain,
                                       input logic gin, input logic addsub,
                                       input logic done);
        return {irin, rout, gout, dinout, rin, ain, gin, addsub, done};
    endfunction

    task automatic chk(input string tag, input logic [22:0] got, input logic [22:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%06h expected=%06h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked mid-cycle
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [22:0] e);
        #4;
        chk(tag, obs, e);
    endtask

    // Bus-select and register-load invariants, every cycle
    always @(negedge Clock) begin
        chk("inv_bus_onehot0", {22'b0, $onehot0({cif.Rout, cif.Gout, cif.DINout})}, 23'd1);
        chk("inv_rin_onehot0", {22'b0, $onehot0(cif.Rin)}, 23'd1);
    end

    localparam logic [22:0] IDLE  = 23'd0;
    localparam logic [22:0] FETCH = 23'h400000;

    initial begin
        n_checks = 0;
        n_errors = 0;
        Resetn   = 1'b0;
        cif.Run  = 1'b1;
        cif.DIN  = 16'h0050;
        cif.Gnz  = 1'b0;

        // Reset holds every output low even with Run=1 in T0
        #3;
        chk("reset_outputs", obs, IDLE);
        tick();
        Resetn = 1'b1;

        // mvi R3,#0x00A5
        cif.Run = 1'b1; cif.DIN = 16'b001_011_000;
        expect_out("mvi_t0", FETCH);
        tick();
        cif.Run = 1'b0; cif.DIN = 16'h00A5;
        expect_out("mvi_t1", ev(0, 8'b0, 0, 1, 8'b00010000, 0, 0, 0, 1));
        tick();
        expect_out("idle_after_mvi", IDLE);
        tick();

        // add R1,R2 with Run asserted during execute (must be ignored)
        cif.Run = 1'b1; cif.DIN = 16'b010_001_010;
        expect_out("add_t0", FETCH);
        tick();
        cif.DIN = 16'h0000;
        expect_out("add_t1", ev(0, 8'b01000000, 0, 0, 8'b0, 1, 0, 0, 0));
        tick();
        expect_out("add_t2", ev(0, 8'b00100000, 0, 0, 8'b0, 0, 1, 0, 0));
        tick();
        expect_out("add_t3", ev(0, 8'b0, 1, 0, 8'b01000000, 0, 0, 0, 1));
        tick();

        // sub R5,R6 fetched immediately after Done
        cif.DIN = 16'b011_101_110;
        expect_out("sub_t0", FETCH);
        tick();
        cif.Run = 1'b0;
        expect_out("sub_t1", ev(0, 8'b00000100, 0, 0, 8'b0, 1, 0, 0, 0));
        tick();
        expect_out("sub_t2", ev(0, 8'b00000010, 0, 0, 8'b0, 0, 1, 1, 0));
        tick();
        expect_out("sub_t3", ev(0, 8'b0, 1, 0, 8'b00000100, 0, 0, 0, 1));
        tick();

        // mv R7,R0 then back-to-back illegal 111
        cif.Run = 1'b1; cif.DIN = 16'b000_111_000;
        expect_out("mv_t0", FETCH);
        tick();
        cif.DIN = 16'b111_010_011;
        expect_out("mv_t1", ev(0, 8'b10000000, 0, 0, 8'b00000001, 0, 0, 0, 1));
        tick();
        expect_out("b2b_fetch", FETCH);
        tick();
        cif.Run = 1'b0;
        expect_out("illegal_t1", ev(0, 8'b0, 0, 0, 8'b0, 0, 0, 0, 1));
        tick();

        // mvnz R2,R4 with Gnz=0 then Gnz=1
        cif.Run = 1'b1; cif.DIN = 16'b100_010_100; cif.Gnz = 1'b0;
        expect_out("mvnz0_t0", FETCH);
        tick();
        cif.Run = 1'b0;
        expect_out("mvnz0_t1", ev(0, 8'b0, 0, 0, 8'b0, 0, 0, 0, 1));
        tick();
        cif.Run = 1'b1; cif.Gnz = 1'b1;
        expect_out("mvnz1_t0", FETCH);
        tick();
        cif.Run = 1'b0;
`ifdef CTRL_MVNZ_EN
        expect_out("mvnz1_t1", ev(0, 8'b00001000, 0, 0, 8'b00100000, 0, 0, 0, 1));
`else
        expect_out("mvnz1_t1", ev(0, 8'b0, 0, 0, 8'b0, 0, 0, 0, 1));
`endif
        tick();
        cif.Gnz = 1'b0;

        // Reset asserted in T2 of an add aborts it
        cif.Run = 1'b1; cif.DIN = 16'b010_011_101;
        expect_out("abort_t0", FETCH);
        tick();
        expect_out("abort_t1", ev(0, 8'b00010000, 0, 0, 8'b0, 1, 0, 0, 0));
        tick();
        expect_out("abort_t2", ev(0, 8'b00000100, 0, 0, 8'b0, 0, 1, 0, 0));
        #1;
        Resetn = 1'b0;
        #1;
        chk("abort_async_zero", obs, IDLE);
        tick();
        expect_out("abort_held_zero", IDLE);
        tick();
        Resetn = 1'b1;
        cif.DIN = 16'b010_001_010;
        expect_out("restart_t0", FETCH);
        tick();
        cif.Run = 1'b0;
        expect_out("restart_t1", ev(0, 8'b01000000, 0, 0, 8'b0, 1, 0, 0, 0));
        tick();
        expect_out("restart_t2", ev(0, 8'b00100000, 0, 0, 8'b0, 0, 1, 0, 0));
        tick();
        expect_out("restart_t3", ev(0, 8'b0, 1, 0, 8'b01000000, 0, 0, 0, 1));
        tick();
        expect_out("final_idle", IDLE);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
